formula_chain_pipe: RTL and testbench

//  Pipelined nested-root evaluator: res = isqrt(x[N-1] + isqrt(... + isqrt(x[1] + isqrt(x[0])))).
//  N_LEVELS isqrt instances in series, each preceded by a registered add stage.

---
 rtl/formula_chain_pipe.sv | 196 +++++++++++++++++++
 tb/tb_formula_chain_pipe.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/formula_chain_pipe.sv
// Pipelined nested-root evaluator:
// res = isqrt(x[N-1] + ... + isqrt(x[1] + isqrt(x[0]))).

// Pipelined integer square root with a sideband tag that travels
// alongside the data and is loaded under the same valid gating.
module formula_chain_isqrt #(
    parameter int W             = 32,
    parameter int N_PIPE_STAGES = 4,
    parameter int TW            = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          x_vld,
    input  logic [W-1:0]  x,
    input  logic [TW-1:0] x_tag,
    output logic          y_vld,
    output logic [W-1:0]  y,
    output logic [TW-1:0] y_tag
);

    localparam int S = N_PIPE_STAGES;

    function automatic logic [W-1:0] root(input logic [W-1:0] v);
        logic [W-1:0] op;
        logic [W-1:0] r;
        logic [W-1:0] one;
        op  = v;
        r   = '0;
        one = {2'b01, {(W-2){1'b0}}};
        for (int i = 0; i < W/2; i++) begin
            if (op >= r + one) begin
                op = op - (r + one);
                r  = (r >> 1) + one;
            end else begin
                r = r >> 1;
            end
            one = one >> 2;
        end
        return r;
    endfunction

    logic [S:1]    pv;
    logic [W-1:0]  pd [1:S];
    logic [TW-1:0] pt [1:S];

    // valid bits shift every cycle and clear on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv[1] <= x_vld;
            for (int j = 2; j <= S; j++)
                pv[j] <= pv[j-1];
        end
    end

    // data and tag stages load only behind a valid entry
    always_ff @(posedge clk) begin
        if (x_vld) begin
            pd[1] <= root(x);
            pt[1] <= x_tag;
        end
        for (int j = 2; j <= S; j++) begin
            if (pv[j-1]) begin
                pd[j] <= pd[j-1];
                pt[j] <= pt[j-1];
            end
        end
    end

    assign y_vld = pv[S];
    assign y     = pd[S];
    assign y_tag = pt[S];

endmodule

module formula_chain_pipe #(
    parameter int N_LEVELS     = 3,
    parameter int W            = 32,
    parameter int ISQRT_STAGES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arg_vld,
    input  logic [N_LEVELS*W-1:0] args,
    output logic                  res_vld,
    output logic [W-1:0]          res,
    output logic                  res_ovf
);

    localparam int LS = ISQRT_STAGES + 1;

    logic         rst_hi;
    logic [W-1:0] y     [N_LEVELS];
    logic         y_vld [N_LEVELS];
    logic         y_ovf [N_LEVELS];

    assign rst_hi = ~rst;

    for (genvar k = 0; k < N_LEVELS; k++) begin : g_lvl
        localparam int DK = k * LS;

        logic [W-1:0] xk;
        logic [W-1:0] yp;
        logic         vin;
        logic         ovf_in;
        logic [W:0]   sum;
        logic [W-1:0] s;
        logic         s_vld;
        logic         s_ovf;

        if (k == 0) begin : g_first
            assign xk     = args[W-1:0];
            assign yp     = '0;
            assign vin    = arg_vld;
            assign ovf_in = 1'b0;
        end else begin : g_next
            logic [W-1:0]  dl  [1:DK];
            logic [DK-1:1] dlv;

            // delay-line valid bits track each parked argument
            always_ff @(posedge clk) begin
                if (!rst) begin
                    dlv <= '0;
                end else begin
                    dlv[1] <= arg_vld;
                    for (int j = 2; j < DK; j++)
                        dlv[j] <= dlv[j-1];
                end
            end

            // x[k] waits here until its partial root arrives
            always_ff @(posedge clk) begin
                if (arg_vld)
                    dl[1] <= args[k*W +: W];
                for (int j = 2; j <= DK; j++)
                    if (dlv[j-1])
                        dl[j] <= dl[j-1];
            end

            assign xk     = dl[DK];
            assign yp     = y[k-1];
            assign vin    = y_vld[k-1];
            assign ovf_in = y_ovf[k-1];
        end

        assign sum = {1'b0, xk} + {1'b0, yp};

        // add-stage valid
        always_ff @(posedge clk) begin
            if (!rst)
                s_vld <= 1'b0;
            else
                s_vld <= vin;
        end

        // add register and sticky wrap flag
        always_ff @(posedge clk) begin
            if (vin) begin
                s     <= sum[W-1:0];
                s_ovf <= sum[W] | ovf_in;
            end
        end

        formula_chain_isqrt #(
            .W             (W),
            .N_PIPE_STAGES (ISQRT_STAGES),
            .TW            (1)
        ) u_isqrt (
            .clk   (clk),
            .rst   (rst_hi),
            .x_vld (s_vld),
            .x     (s),
            .x_tag (s_ovf),
            .y_vld (y_vld[k]),
            .y     (y[k]),
            .y_tag (y_ovf[k])
        );
    end

    // output register holds its value between results
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_vld <= 1'b0;
            res     <= '0;
            res_ovf <= 1'b0;
        end else begin
            res_vld <= y_vld[N_LEVELS-1];
            if (y_vld[N_LEVELS-1]) begin
                res     <= y[N_LEVELS-1];
                res_ovf <= y_ovf[N_LEVELS-1];
            end
        end
    end

endmodule

// File: tb/tb_formula_chain_pipe.sv
// Scoreboard bench for formula_chain_pipe.
// Directed scenarios plus a random stream.
module tb_formula_chain_pipe;

    localparam int N = 3;
    localparam int W = 32;
    localparam int S = 4;
    localparam int L = N * (S + 1) + 1;

    typedef struct packed {
        logic [31:0]  cyc;
        logic         ovf;
        logic [W-1:0] res;
    } rec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           arg_vld = 1'b0;
    logic [N*W-1:0] args = '0;
    logic           res_vld;
    logic [W-1:0]   res;
    logic           res_ovf;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   gap_chg  = 0;
    logic [W-1:0] last_res = '0;

    rec_t exp_q [$];
    rec_t obs_q [$];

    formula_chain_pipe #(
        .N_LEVELS     (N),
        .W            (W),
        .ISQRT_STAGES (S)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .arg_vld (arg_vld),
        .args    (args),
        .res_vld (res_vld),
        .res     (res),
        .res_ovf (res_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (res_vld)
            obs_q.push_back({cyc[31:0], res_ovf, res});
        else if (res !== last_res)
            gap_chg++;
        last_res = res;
    end

    function automatic logic [W-1:0] ref_root(input logic [W-1:0] v);
        longint unsigned r;
        longint unsigned t;
        longint unsigned vv;
        r  = 0;
        vv = longint'(v);
        for (int b = W/2 - 1; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= vv)
                r = t;
        end
        return r[W-1:0];
    endfunction

    function automatic logic [W:0] model(input logic [N*W-1:0] a);
        logic [W-1:0] yv;
        logic [W:0]   acc;
        logic         ov;
        yv = '0;
        ov = 1'b0;
        for (int k = 0; k < N; k++) begin
            acc = {1'b0, a[k*W +: W]} + {1'b0, yv};
            ov  = ov | acc[W];
            yv  = ref_root(acc[W-1:0]);
        end
        return {ov, yv};
    endfunction

    function automatic logic [N*W-1:0] pack3(
        input logic [W-1:0] c,
        input logic [W-1:0] b,
        input logic [W-1:0] a
    );
        return {a, b, c};
    endfunction

    task automatic send(
        input logic [N*W-1:0] a,
        input logic [W-1:0]   r,
        input logic           o
    );
        rec_t e;
        @(posedge clk);
        #1;
        arg_vld = 1'b1;
        args    = a;
        e.cyc = 32'(cyc + L);
        e.ovf = o;
        e.res = r;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        arg_vld = 1'b0;
        args    = '0;
    endtask

    task automatic wait_drain(output bit ok);
        for (int i = 0; i < L + 8; i++) begin
            if (obs_q.size() >= exp_q.size()) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        ok = (obs_q.size() == exp_q.size());
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (res_vld !== 1'b0) begin
            failures++;
            $display("FAIL rst_vld got=%b want=0", res_vld);
        end
        checks++;
        if (res !== '0) begin
            failures++;
            $display("FAIL rst_res got=%0h want=0", res);
        end
        checks++;
        if (res_ovf !== 1'b0) begin
            failures++;
            $display("FAIL rst_ovf got=%b want=0", res_ovf);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_single();
        bit   ok;
        rec_t e;
        rec_t o;
        send(pack3(16, 5, 6), 3, 1'b0);
        idle();
        wait_drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_cnt got=%0d want=%0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL single got=%h want=%h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        bit   ok;
        rec_t e;
        rec_t o;
        send(pack3(0, 0, 0), 0, 1'b0);
        send(pack3(1, 3, 2), 2, 1'b0);
        send(pack3(16, 5, 6), 3, 1'b0);
        idle();
        wait_drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_cnt got=%0d want=%0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b got=%h want=%h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_gaps();
        bit   ok;
        rec_t e;
        rec_t o;
        gap_chg = 0;
        send(pack3(16, 5, 6), 3, 1'b0);
        idle();
        send(pack3(1, 3, 2), 2, 1'b0);
        send(pack3(0, 0, 0), 0, 1'b0);
        idle();
        wait_drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL gap_cnt got=%0d want=%0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL gap got=%h want=%h", o, e);
            end
        end
        checks++;
        if (gap_chg != 0) begin
            failures++;
            $display("FAIL gap_hold got=%0d want=0", gap_chg);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_overflow();
        bit   ok;
        rec_t e;
        rec_t o;
        send(pack3(1, 0, 32'hFFFF_FFFF), 0, 1'b1);
        send(pack3(16, 5, 6), 3, 1'b0);
        idle();
        wait_drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL ovf_cnt got=%0d want=%0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL ovf got=%h want=%h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_mid_reset();
        bit   ok;
        rec_t e;
        rec_t o;
        for (int i = 0; i < 5; i++)
            send(pack3(32'(i), 7, 9), 0, 1'b0);
        @(posedge clk);
        #1;
        arg_vld = 1'b0;
        rst     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        repeat (L + 6) @(posedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL mrst_flush got=%0d want=0", obs_q.size());
        end
        obs_q.delete();
        repeat (3) idle();
        send(pack3(16, 5, 6), 3, 1'b0);
        idle();
        wait_drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL mrst_cnt got=%0d want=%0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL mrst got=%h want=%h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_random();
        bit             ok;
        rec_t           e;
        rec_t           o;
        logic [N*W-1:0] a;
        logic [W:0]     m;
        logic [W-1:0]   v;
        int             bad;
        bad = 0;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(9) < 3) idle();
            for (int k = 0; k < N; k++) begin
                case ($urandom_range(3))
                    0: v = W'($urandom_range(255));
                    1: v = ~W'($urandom_range(70000));
                    default: v = W'($urandom);
                endcase
                a[k*W +: W] = v;
            end
            m = model(a);
            send(a, m[W-1:0], m[W]);
        end
        idle();
        wait_drain(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rnd_cnt got=%0d want=%0d",
                     obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                if (bad < 10)
                    $display("FAIL rnd got=%h want=%h", o, e);
                bad++;
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gaps();
        test_overflow();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
